// File: rtl/divshift.sv
// divshift: iterative restoring divider computing q = (num << SHIFT) / den.
// One quotient bit per clock, valid/ready handshake on both sides, quotient
// saturated to WIDTH_Q bits with an overflow flag, divide-by-zero flagged.
module divshift #(
   parameter int WIDTH_N = 17,
   parameter int WIDTH_D = 9,
   parameter int WIDTH_Q = 8,
   parameter int SHIFT   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH_N-1:0] num,
   input  logic [WIDTH_D-1:0] den,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_Q-1:0] quo,
   output logic [WIDTH_D-1:0] rem,
   output logic               ovf,
   output logic               dbz
);

   localparam int N     = WIDTH_N + SHIFT;
   localparam int CNT_W = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [N-1:0]       dividend;
   logic [N-1:0]       quotient;
   logic [WIDTH_D:0]   prem;
   logic [WIDTH_D-1:0] den_r;

   logic               accept;
   logic               last_iter;
   logic [WIDTH_D:0]   trial;
   logic               qbit;
   logic [WIDTH_D:0]   prem_next;
   logic [N-1:0]       quotient_next;

   // Any quotient bit at or above WIDTH_Q means the result does not fit.
   function automatic logic quo_ovf(input logic [N-1:0] q);
      return |q[N-1:WIDTH_Q];
   endfunction

   // Clamp the full quotient to all ones when it does not fit in WIDTH_Q bits.
   function automatic logic [WIDTH_Q-1:0] sat_quo(input logic [N-1:0] q);
      if (quo_ovf(q))
         return '1;
      else
         return q[WIDTH_Q-1:0];
   endfunction

   assign accept    = in_valid && (state == IDLE);
   assign last_iter = (state == BUSY) && (cnt == CNT_W'(1));

   // One restoring step: the partial remainder is always < den, so it fits
   // WIDTH_D bits before the shift and WIDTH_D+1 bits after it.
   always_comb begin
      trial         = {prem[WIDTH_D-1:0], dividend[N-1]};
      qbit          = (trial >= {1'b0, den_r});
      prem_next     = qbit ? (trial - {1'b0, den_r}) : trial;
      quotient_next = {quotient[N-2:0], qbit};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_next = (den == '0) ? DONE : BUSY;
         end
         BUSY: begin
            if (cnt == CNT_W'(1))
               state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Iteration counter: loaded with N on accept, counts down while busy.
   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (accept)
         cnt <= CNT_W'(N);
      else if (state == BUSY)
         cnt <= cnt - CNT_W'(1);
   end

   // Working registers: operands captured on accept, shifted while busy.
   always_ff @(posedge clk) begin
      if (accept) begin
         dividend <= N'(num) << SHIFT;
         den_r    <= den;
         prem     <= '0;
         quotient <= '0;
      end else if (state == BUSY) begin
         dividend <= dividend << 1;
         prem     <= prem_next;
         quotient <= quotient_next;
      end
   end

   // Result registers: written on entry to DONE and held until the next op.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         quo <= '0;
         rem <= '0;
         ovf <= 1'b0;
         dbz <= 1'b0;
      end else if (accept && (den == '0)) begin
         quo <= '1;
         rem <= '0;
         ovf <= 1'b0;
         dbz <= 1'b1;
      end else if (last_iter) begin
         quo <= sat_quo(quotient_next);
         rem <= prem_next[WIDTH_D-1:0];
         ovf <= quo_ovf(quotient_next);
         dbz <= 1'b0;
      end
   end

endmodule
